// File: rtl/router_arb_pkg.sv
// Shared definitions for the router output-port arbiter: FSM encoding, port
// indices and head-flit field positions.
package router_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2,
        TAIL = 2'd3
    } arb_state_t;

    localparam int P_N = 0;
    localparam int P_E = 1;
    localparam int P_S = 2;
    localparam int P_W = 3;
    localparam int P_L = 4;

    localparam int NPORT_DEF   = 5;
    localparam int FLIT_W      = 8;
    localparam int HEAD_BIT    = FLIT_W - 1;
    localparam int LEN_LSB     = 0;
    localparam int LEN_W       = 3;
    localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester strictly after ptr_i
// (wrapping NPORT-1 -> 0) wins; ptr_i itself has the lowest priority.
module rr_pick #(
    parameter int NPORT = 5,
    parameter int PW    = 3
) (
    input  logic [NPORT-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [NPORT-1:0] gnt_o,
    output logic [PW-1:0]    idx_o,
    output logic             valid_o
);

    logic [PW-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NPORT; k++) begin
            cand = PW'((int'(ptr_i) + k) % NPORT);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_out_arb.sv
// Output-link arbiter: round-robin between input FIFOs with wormhole locking.
// Optional stall abort for a locked packet is enabled by defining ARB_TIMEOUT_EN.
module router_out_arb #(
    parameter int NPORT   = router_arb_pkg::NPORT_DEF,
    parameter int FW      = router_arb_pkg::FLIT_W,
    parameter int LEN_W   = router_arb_pkg::LEN_W,
    parameter int TIMEOUT = router_arb_pkg::TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NPORT-1:0]           req,
    input  logic [NPORT*FW-1:0]        fifo_do,
    output logic [NPORT-1:0]           rd,
    input  logic                       out_rdy,
    output logic                       out_vld,
    output logic [FW-1:0]              out_dat,
    output logic [NPORT-1:0]           gnt,
    output logic                       err,
    output router_arb_pkg::arb_state_t state_dbg
);

    import router_arb_pkg::*;

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    arb_state_t       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [NPORT-1:0] gnt_q, gnt_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             vld_q;
    logic             err_q, err_d;
    logic [NPORT-1:0] rd_d;

    logic [NPORT-1:0] pick_oh;
    logic [PW-1:0]    pick_idx;
    logic             pick_vld;

    logic [FW-1:0]    flit;
    logic [LEN_W-1:0] head_len;
    logic             own_ok;
    logic             to_hit;

    rr_pick #(
        .NPORT (NPORT),
        .PW    (PW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_oh),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    // The FIFO output register supplies the flit one cycle after its read strobe.
    assign flit     = fifo_do[int'(owner_q)*FW +: FW];
    assign head_len = flit[FW-1] ? flit[LEN_LSB +: LEN_W] : '0;
    assign own_ok   = req[owner_q] && out_rdy;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_q, to_d;

    assign to_hit = (state_q == BODY) && !req[owner_q] && (to_q == TW'(TIMEOUT - 1));

    always_comb begin
        to_d = to_q;
        if (state_q != BODY || |rd_d) begin
            to_d = '0;
        end else if (!req[owner_q]) begin
            to_d = to_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        rem_d   = rem_q;
        rd_d    = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld && out_rdy) begin
                    rd_d    = pick_oh;
                    gnt_d   = pick_oh;
                    owner_d = pick_idx;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                // The head is visible now, so the first body read can start
                // here and keep the packet back-to-back on the link.
                if (head_len == '0) begin
                    gnt_d   = '0;
                    ptr_d   = owner_q;
                    rem_d   = '0;
                    state_d = IDLE;
                end else if (own_ok) begin
                    rd_d[owner_q] = 1'b1;
                    rem_d         = head_len - 1'b1;
                    state_d       = (head_len == LEN_W'(1)) ? TAIL : BODY;
                end else begin
                    rem_d   = head_len;
                    state_d = BODY;
                end
            end
            BODY: begin
                if (to_hit) begin
                    err_d   = 1'b1;
                    gnt_d   = '0;
                    ptr_d   = owner_q;
                    rem_d   = '0;
                    state_d = IDLE;
                end else if (own_ok && rem_q != '0) begin
                    rd_d[owner_q] = 1'b1;
                    rem_d         = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                gnt_d   = '0;
                ptr_d   = owner_q;
                rem_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NPORT - 1);
            owner_q <= '0;
            gnt_q   <= '0;
            rem_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            rem_q   <= rem_d;
            vld_q   <= |rd_d;
            err_q   <= err_d;
        end
    end

    // No FIFO is popped while reset is held, so nothing is lost at release.
    assign rd        = rst ? rd_d : '0;
    assign out_vld   = vld_q;
    assign out_dat   = vld_q ? flit : '0;
    assign gnt       = gnt_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule
